result_display: RTL and testbench
=================================

Name: result_display

Overview:
- Downstream consumer of the 3-bit sign-magnitude add/sub stage.
- Captures the 4-bit sign-magnitude result with a valid/ready handshake and holds it.
- Drives a two-digit, time-multiplexed seven-segment display: digit 1 shows the sign, digit 0 shows the magnitude.
- Enforces a minimum display time before a new result is accepted.

Parameters:
- REFRESH_DIV, 1000: clock cycles each digit stays enabled before the scan toggles; legal range ≥ 2.
- HOLD_CYCLES, 8: cycles after a capture during which no new result is accepted; legal range ≥ 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- res_valid  input  1  upstream result valid.
- res_ready  output  1  block can accept a result; combinational from state and clr.
- result  input  4  sign-magnitude result: bit 3 = sign (1 = negative), bits 2:0 = magnitude 0..7.
- clr  input  1  synchronous blank request.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high, registered.
- an  output  2  digit enables, active-high, registered: 01 = magnitude digit, 10 = sign digit.
- err  output  1  out-of-range indicator, registered; see Optional Feature.

Behaviour:
- States:
  - BLANK: nothing displayed; ready.
  - HOLD: displaying; not ready.
  - SHOW: displaying; ready.
- Reset values (rst=1 at an edge): state=BLANK, seg=0000000, an=00, err=0, latched value=0, refresh counter=0, digit select=0, hold counter=0.
- res_ready = (state != HOLD) && !clr.
- Accept: occurs on an edge where res_valid && res_ready.
  - result is latched.
  - Refresh counter and digit select are cleared to 0.
  - Hold counter is loaded with HOLD_CYCLES-1.
  - state becomes HOLD.
  - Legal from BLANK and SHOW.
- HOLD: hold counter decrements each cycle; at 0 the next edge moves to SHOW. res_ready is low for exactly HOLD_CYCLES cycles after the accept edge.
- SHOW: latched value is displayed indefinitely until the next accept or clr.
- clr=1 at an edge:
  - Any state → BLANK; latched value is unchanged.
  - Priority: rst > clr > accept.
  - No accept can coincide with clr, because res_ready is forced low.
- Scan (HOLD and SHOW only):
  - Refresh counter runs 0..REFRESH_DIV-1.
  - On wrap, digit select toggles.
  - Frozen at 0 in BLANK.
- Output register (updates every edge from the current state, latched value and digit select; one-cycle latency):
  - BLANK: seg=0000000, an=00.
  - Digit select 0: an=01; seg = glyph of magnitude.
  - Digit select 1: an=10; seg = minus (1000000) if sign=1 and magnitude≠0, else blank.
  - Negative zero (1000) therefore displays as plain "0".
- Glyphs:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111.
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111.
  - E=1111001.
- First display: seg/an show the new value from the edge after the accept edge.
- Back-to-back: a result presented continuously is re-accepted on the first edge of SHOW. Each acceptance restarts the scan at digit 0.
- res_valid while in HOLD: ignored. The upstream value must be held until res_ready is seen high.

Optional Feature:
- Macro: RESULT_DISPLAY_OVF_EN.
- Defined: magnitude 7 is treated as overflow (unreachable from two 3-bit sign-magnitude operands).
  - Magnitude digit shows E; sign digit is blank.
  - err=1 while in HOLD/SHOW with magnitude 7; err=0 in BLANK and on other values.
- Undefined: magnitude 7 shows glyph 7 with the normal sign rule; err is tied to 0.

Test Plan:
- Reset, then idle 10 cycles → seg=0000000, an=00, err=0, res_ready=1.
- result=1101 (−5) with res_valid=1 for one cycle, REFRESH_DIV=4:
  - Next edge: an=01, seg=1101101.
  - After 4 cycles: an=10, seg=1000000.
  - Digits continue alternating every 4 cycles.
- Hold window, HOLD_CYCLES=8: res_valid held high with 0011 after accepting 0110:
  - res_ready low for exactly 8 cycles.
  - 0011 accepted on the first SHOW edge.
  - Magnitude digit becomes 1001111.
- result=1000 accepted → magnitude digit 0111111; sign digit blank, never 1000000.
- clr and res_valid high on the same edge in SHOW:
  - res_ready=0; state → BLANK; an=00 next cycle.
  - Latched value unchanged; no accept occurs.
- result=0111:
  - With RESULT_DISPLAY_OVF_EN: magnitude digit 1111001, err=1.
  - Without it: 0000111, err=0.
- rst asserted mid-HOLD → all outputs return to reset values on the next edge; res_ready=1.

Source files
------------

// File: rtl/result_display.sv
// Result display: captures a 4-bit sign-magnitude result and shows it on a two-digit
// time-multiplexed seven-segment display (digit 1 = sign, digit 0 = magnitude).
// A new result is only accepted after the current one has been held for HOLD_CYCLES.
// Optional feature macro: RESULT_DISPLAY_OVF_EN shows magnitude 7 as 'E' and raises err.
module result_display #(
  parameter int unsigned REFRESH_DIV = 1000,
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       res_valid,
  output logic       res_ready,
  input  logic [3:0] result,
  input  logic       clr,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       err
);

  localparam int unsigned RefW  = $clog2(REFRESH_DIV);
  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [RefW-1:0]  RefMax   = RefW'(REFRESH_DIV - 1);
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES - 1);
  localparam logic [6:0] SegMinus = 7'b1000000;
  localparam logic [6:0] SegE     = 7'b1111001;
  localparam logic [6:0] SegBlank = 7'b0000000;

  typedef enum logic [1:0] {StBlank, StHold, StShow} state_e;

  state_e            state_q, state_d;
  logic [3:0]        val_q, val_d;
  logic [RefW-1:0]   ref_q, ref_d;
  logic              sel_q, sel_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [6:0]        seg_q, seg_d;
  logic [1:0]        an_q, an_d;
  logic              err_q, err_d;
  logic              accept;
  logic              ovf;

  function automatic logic [6:0] glyph(input logic [2:0] mag);
    logic [6:0] g;
    case (mag)
      3'd0:    g = 7'b0111111;
      3'd1:    g = 7'b0000110;
      3'd2:    g = 7'b1011011;
      3'd3:    g = 7'b1001111;
      3'd4:    g = 7'b1100110;
      3'd5:    g = 7'b1101101;
      3'd6:    g = 7'b1111101;
      default: g = 7'b0000111;
    endcase
    return g;
  endfunction

`ifdef RESULT_DISPLAY_OVF_EN
  // Magnitude 7 cannot come from two 3-bit operands, so it flags an upstream fault.
  assign ovf = (val_q[2:0] == 3'd7);
`else
  assign ovf = 1'b0;
`endif

  assign res_ready = (state_q != StHold) && !clr;
  assign accept    = res_valid && res_ready;

  // Next state: clr beats accept; accept restarts the scan at digit 0.
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    ref_d   = ref_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    if (clr) begin
      state_d = StBlank;
      ref_d   = '0;
      sel_d   = 1'b0;
    end else if (accept) begin
      state_d = StHold;
      val_d   = result;
      ref_d   = '0;
      sel_d   = 1'b0;
      hold_d  = HoldLoad;
    end else begin
      case (state_q)
        StHold: begin
          if (hold_q == '0) begin
            state_d = StShow;
          end else begin
            hold_d = hold_q - HoldW'(1);
          end
        end
        StShow: ;
        default: begin
          state_d = StBlank;
          ref_d   = '0;
          sel_d   = 1'b0;
        end
      endcase
      if (state_q != StBlank) begin
        if (ref_q == RefMax) begin
          ref_d = '0;
          sel_d = ~sel_q;
        end else begin
          ref_d = ref_q + RefW'(1);
        end
      end
    end
  end

  // Display decode from the pre-edge state, registered for glitch-free outputs.
  always_comb begin
    seg_d = SegBlank;
    an_d  = 2'b00;
    err_d = 1'b0;
    if (state_q != StBlank) begin
      err_d = ovf;
      if (!sel_q) begin
        an_d  = 2'b01;
        seg_d = ovf ? SegE : glyph(val_q[2:0]);
      end else begin
        an_d  = 2'b10;
        // Negative zero shows no minus sign.
        seg_d = (!ovf && val_q[3] && (val_q[2:0] != 3'd0)) ? SegMinus : SegBlank;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StBlank;
      val_q   <= '0;
      ref_q   <= '0;
      sel_q   <= 1'b0;
      hold_q  <= '0;
      seg_q   <= '0;
      an_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      ref_q   <= ref_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      err_q   <= err_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign err = err_q;

endmodule

// File: tb/tb_result_display.sv
// Bench for result_display: time-since-accept reference model checked every cycle,
// plus directed literal checks, then randomized traffic.
module tb_result_display;

  localparam int unsigned R = 4;
  localparam int unsigned H = 8;
`ifdef RESULT_DISPLAY_OVF_EN
  localparam bit Ovf = 1'b1;
`else
  localparam bit Ovf = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] result;
  logic       clr;
  logic [6:0] seg;
  logic [1:0] an;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  result_display #(.REFRESH_DIV(R), .HOLD_CYCLES(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .clr       (clr),
    .seg       (seg),
    .an        (an),
    .err       (err)
  );

  logic [6:0] glyphs [8] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                             7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111};

  // Reference model: display content follows from the time elapsed since the last accept.
  int         cyc     = 0;
  bit         m_init  = 1'b0;
  bit         m_blank = 1'b1;
  int         m_acc   = 0;
  logic [3:0] m_val   = 4'd0;
  logic [6:0] e_seg   = 7'd0;
  logic [1:0] e_an    = 2'd0;
  logic       e_err   = 1'b0;

  always @(posedge clk) begin : model
    bit         pre_blank, pre_hold, rdy, o;
    int         k;
    logic [2:0] mag;
    cyc++;
    pre_blank = m_blank;
    pre_hold  = !m_blank && ((cyc - m_acc) <= int'(H));
    rdy       = !pre_hold && !clr;
    if (rst) begin
      m_init  = 1'b1;
      m_blank = 1'b1;
      m_val   = 4'd0;
      e_seg   = 7'd0;
      e_an    = 2'd0;
      e_err   = 1'b0;
    end else begin
      if (pre_blank) begin
        e_seg = 7'd0;
        e_an  = 2'd0;
        e_err = 1'b0;
      end else begin
        mag = m_val[2:0];
        o   = Ovf && (mag == 3'd7);
        k   = cyc - 1 - m_acc;
        if (((k / int'(R)) % 2) == 0) begin
          e_an  = 2'b01;
          e_seg = o ? 7'b1111001 : glyphs[mag];
        end else begin
          e_an  = 2'b10;
          e_seg = (!o && m_val[3] && mag != 3'd0) ? 7'b1000000 : 7'b0000000;
        end
        e_err = o;
      end
      if (clr) begin
        m_blank = 1'b1;
      end else if (res_valid && rdy) begin
        m_acc   = cyc;
        m_val   = result;
        m_blank = 1'b0;
      end
    end
  end

  // Compare every cycle, mid-period, once the model has seen a reset.
  always @(negedge clk) begin : compare
    bit e_rdy;
    if (m_init) begin
      e_rdy = !(!m_blank && ((cyc + 1 - m_acc) <= int'(H))) && !clr;
      n_tests++;
      if (seg !== e_seg || an !== e_an || err !== e_err || res_ready !== e_rdy) begin
        n_fail++;
        $display("FAIL model cycle %0d: dut seg=%b an=%b err=%b rdy=%b, model seg=%b an=%b err=%b rdy=%b",
                 cyc, seg, an, err, res_ready, e_seg, e_an, e_err, e_rdy);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready(input string name);
    int i;
    i = 0;
    while (!res_ready && i < 50) begin
      step();
      i++;
    end
    n_tests++;
    if (!res_ready) begin
      n_fail++;
      $display("FAIL %s: res_ready stayed 0, expected 1 within 50 cycles", name);
    end
  endtask

  initial begin : stim
    int lows;
    rst       = 1'b1;
    res_valid = 1'b0;
    clr       = 1'b0;
    result    = 4'd0;
    step(2);
    rst = 1'b0;
    step(10);
    chk("idle_seg", 32'(seg), 32'b0000000);
    chk("idle_an", 32'(an), 32'b00);
    chk("idle_err", 32'(err), 32'b0);
    chk("idle_ready", 32'(res_ready), 32'b1);

    // -5 with refresh every 4 cycles
    result    = 4'b1101;
    res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    step();
    chk("neg5_an0", 32'(an), 32'b01);
    chk("neg5_seg0", 32'(seg), 32'b1101101);
    step(4);
    chk("neg5_an1", 32'(an), 32'b10);
    chk("neg5_seg1", 32'(seg), 32'b1000000);
    step(4);
    chk("neg5_an2", 32'(an), 32'b01);

    // Hold window with a continuously presented follow-up result
    wait_ready("ready_before_6");
    result    = 4'b0110;
    res_valid = 1'b1;
    step();
    result = 4'b0011;
    lows   = 0;
    while (!res_ready && lows < 50) begin
      lows++;
      step();
    end
    chk("hold_len", 32'(lows), 32'd8);
    step();
    res_valid = 1'b0;
    step();
    chk("b2b_an", 32'(an), 32'b01);
    chk("b2b_seg", 32'(seg), 32'b1001111);

    // Negative zero
    wait_ready("ready_before_nz");
    result    = 4'b1000;
    res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    step();
    chk("nz_seg0", 32'(seg), 32'b0111111);
    step(4);
    chk("nz_an1", 32'(an), 32'b10);
    chk("nz_seg1", 32'(seg), 32'b0000000);

    // clr together with res_valid in SHOW
    wait_ready("ready_before_clr");
    result    = 4'b0101;
    res_valid = 1'b1;
    clr       = 1'b1;
    #1;
    chk("clr_ready", 32'(res_ready), 32'b0);
    step();
    clr       = 1'b0;
    res_valid = 1'b0;
    step();
    chk("clr_an", 32'(an), 32'b00);
    chk("clr_seg", 32'(seg), 32'b0000000);

    // Magnitude 7
    result    = 4'b0111;
    res_valid = 1'b1;
    step();
    res_valid = 1'b0;
    step();
    chk("m7_an", 32'(an), 32'b01);
    chk("m7_seg", 32'(seg), Ovf ? 32'b1111001 : 32'b0000111);
    chk("m7_err", 32'(err), Ovf ? 32'b1 : 32'b0);

    // Reset in the middle of HOLD
    step(2);
    rst = 1'b1;
    step();
    chk("rst_seg", 32'(seg), 32'b0000000);
    chk("rst_an", 32'(an), 32'b00);
    chk("rst_err", 32'(err), 32'b0);
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(res_ready), 32'b1);

    // Randomized traffic, checked by the model every cycle
    repeat (3000) begin
      result    = 4'($urandom);
      res_valid = ($urandom % 3) != 0;
      clr       = ($urandom % 40) == 0;
      rst       = ($urandom % 300) == 0;
      step();
    end
    rst       = 1'b0;
    clr       = 1'b0;
    res_valid = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
